// File: rtl/alu_seq_mult_if.sv
// rtl/alu_seq_mult_if.sv - start/busy/done operand and product bundle for alu_seq_mult
interface alu_seq_mult_if #(
  parameter int W = 32
);
  logic         start;
  logic         signed_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/alu_seq_mult.sv
// rtl/alu_seq_mult.sv - iterative radix-2 shift-and-add multiplier, W x W -> 2W
// Signed operands become magnitudes before the loop; the product is negated afterwards.
module alu_seq_mult #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_mult_if.slave bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST_STEP = CW'(W - 1);
  localparam logic [CW-1:0]  ONE_C     = CW'(1);
  localparam logic [W-1:0]   ONE_W     = W'(1);
  localparam logic [2*W-1:0] ONE_2W    = (2*W)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAG,
    S_MUL,
    S_FIX,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           signed_q, signed_d;
  logic           neg_q, neg_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [2*W-1:0] result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result   = neg_q ? ((~acc_q) + ONE_2W) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          signed_d = bus.signed_op;
          state_d  = S_MAG;
        end
      end
      S_MAG: begin
        neg_d    = signed_q & (mcand_q[W-1] ^ mplier_q[W-1]);
        // -2^(W-1) negates to itself, which is exactly its unsigned magnitude
        mcand_d  = (signed_q & mcand_q[W-1])  ? ((~mcand_q) + ONE_W)  : mcand_q;
        mplier_d = (signed_q & mplier_q[W-1]) ? ((~mplier_q) + ONE_W) : mplier_q;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_MUL;
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{W{1'b0}}, mcand_q} << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + ONE_C;
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        hi_d    = result[2*W-1:W];
        lo_d    = result[W-1:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == S_MAG) || (state_q == S_MUL) || (state_q == S_FIX);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_alu_seq_mult.sv
// tb/tb_alu_seq_mult.sv - self-checking bench for alu_seq_mult (W=32)
module tb_alu_seq_mult;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  int   done_cnt;
  int   overlap_cnt;

  alu_seq_mult_if #(.W(W)) mif ();

  alu_seq_mult #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.done) done_cnt <= done_cnt + 1;
    if (mif.done && mif.busy) overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: full-precision product of the sign- or zero-extended operands
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ex, ey;
    ex = s ? {{32{x[31]}}, x} : {32'b0, x};
    ey = s ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int lat, output logic busy_at_done, output logic done_after);
    @(negedge clk);
    mif.a = ta;
    mif.b = tb_v;
    mif.signed_op = ts;
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.a = $urandom;
    mif.b = $urandom;
    mif.signed_op = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (mif.done) begin
        lat = k;
        break;
      end
    end
    rhi = mif.hi;
    rlo = mif.lo;
    busy_at_done = mif.busy;
    @(posedge clk);
    #1;
    done_after = mif.done;
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] rhi, rlo, ra, rb;
    logic        rs, bsy, dafter;
    logic [63:0] expv;
    int          lat, snap;

    pass_cnt = 0;
    total_cnt = 0;
    done_cnt = 0;
    overlap_cnt = 0;

    vecs[0] = '{"u_max",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"s_m3x5",    32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"s_m1xm1",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
    vecs[3] = '{"s_minxmin", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[4] = '{"s_minx1",   32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};
    vecs[5] = '{"s_zero",    32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000};
    vecs[6] = '{"u_minxmin", 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    vecs[7] = '{"s_7xm9",    32'h00000007, 32'hFFFFFFF7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFC1};
    vecs[8] = '{"u_maxx2",   32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE};

    rst = 1'b1;
    mif.start = 1'b0;
    mif.signed_op = 1'b0;
    mif.a = '0;
    mif.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_done", 64'(mif.done), 64'd0);
    check("rst_hi", 64'(mif.hi), 64'd0);
    check("rst_lo", 64'(mif.lo), 64'd0);
    snap = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("idle_no_done", 64'(done_cnt - snap), 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, rhi, rlo, lat, bsy, dafter);
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(LAT));
      check({vecs[i].name, "_hi"}, 64'(rhi), 64'(vecs[i].hi));
      check({vecs[i].name, "_lo"}, 64'(rlo), 64'(vecs[i].lo));
      check({vecs[i].name, "_busy_at_done"}, 64'(bsy), 64'd0);
      check({vecs[i].name, "_done_width"}, 64'(dafter), 64'd0);
    end

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (n % 6 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
      if (n % 7 == 0) rb = 32'($urandom_range(0, 2));
      run_op(ra, rb, rs, rhi, rlo, lat, bsy, dafter);
      expv = ref_mul(ra, rb, rs);
      check("rand_lat", 64'(lat), 64'(LAT));
      check("rand_prod", {rhi, rlo}, expv);
    end

    // Stray starts during MUL and DONE must be ignored; start held into IDLE is taken once
    snap = done_cnt;
    @(negedge clk);
    mif.a = 32'h12345678;
    mif.b = 32'h9ABCDEF0;
    mif.signed_op = 1'b0;
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.a = 32'hDEADBEEF;
    mif.b = 32'h0BADF00D;
    mif.signed_op = 1'b1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      mif.start = (k == 5);
      if (mif.done) begin
        lat = k;
        break;
      end
    end
    check("hs_first_lat", 64'(lat), 64'(LAT));
    check("hs_first_prod", {mif.hi, mif.lo}, ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0));
    mif.a = 32'hFFFF0001;
    mif.b = 32'h00007FFF;
    mif.signed_op = 1'b1;
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (mif.done) begin
        lat = k;
        break;
      end
    end
    check("hs_second_lat", 64'(lat), 64'(LAT));
    check("hs_second_prod", {mif.hi, mif.lo}, ref_mul(32'hFFFF0001, 32'h00007FFF, 1'b1));
    @(posedge clk);
    #1;
    check("hs_done_pulses", 64'(done_cnt - snap), 64'd2);

    snap = done_cnt;
    @(negedge clk);
    mif.a = 32'd7;
    mif.b = 32'd9;
    mif.signed_op = 1'b0;
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(mif.busy), 64'd0);
    check("midrst_done", 64'(mif.done), 64'd0);
    check("midrst_hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - snap), 64'd0);
    run_op(32'd7, 32'd9, 1'b0, rhi, rlo, lat, bsy, dafter);
    check("post_rst_lat", 64'(lat), 64'(LAT));
    check("post_rst_lo", 64'(rlo), 64'd63);
    check("post_rst_hi", 64'(rhi), 64'd0);

    check("busy_done_overlap", 64'(overlap_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
